// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - two-master burst-aware AHB bus arbiter
//
// Purpose:
//   Arbitrates the CPU (master 0) and DMA (master 1) AHB master ports and
//   drives the grant/owner selects for the master-to-slave multiplexer.
//   A granted master keeps the bus for the whole of a fixed-length burst,
//   for as long as it holds an undefined-length (INCR) request, and for as
//   long as it holds HLOCK. With no request the grant parks on the CPU.
//
// Build option:
//   AHB_ARB_ROUND_ROBIN_EN  defined     -> round-robin on contention
//                           not defined -> fixed priority, CPU over DMA
//
// Ports:
//   HCLK       in   bus clock, all state on the rising edge
//   HRESETn    in   asynchronous active-low reset
//   HBUSREQ    in   per-master bus request (bit 0 CPU, bit 1 DMA)
//   HLOCK      in   per-master locked-transfer request
//   HTRANS     in   transfer type of the address-phase owner
//   HBURST     in   burst type of the address-phase owner
//   HREADY     in   bus ready from the slave-response mux
//   HRESP      in   slave response
//   HGRANT     out  one-hot grant, registered
//   HMASTER    out  current address-phase owner, registered
//   HMASTLOCK  out  current address phase is locked, registered

package ahb_arb_pkg;

    localparam int NO_OF_MASTERS = 2;
    localparam int MASTER_W      = $clog2(NO_OF_MASTERS);

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_t;

    typedef logic [MASTER_W-1:0] hmaster_t;

    localparam hmaster_t MASTER_CPU = hmaster_t'(0);
    localparam hmaster_t MASTER_DMA = hmaster_t'(1);

endpackage

module ahb_arbiter
    import ahb_arb_pkg::*;
(
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NO_OF_MASTERS-1:0] HBUSREQ,
    input  logic [NO_OF_MASTERS-1:0] HLOCK,
    input  logic [1:0]               HTRANS,
    input  logic [2:0]               HBURST,
    input  logic                     HREADY,
    input  logic [1:0]               HRESP,
    output logic [NO_OF_MASTERS-1:0] HGRANT,
    output hmaster_t                 HMASTER,
    output logic                     HMASTLOCK
);

    typedef enum logic [1:0] {
        ST_PARK  = 2'd0,
        ST_OWN   = 2'd1,
        ST_BURST = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam logic [NO_OF_MASTERS-1:0] GRANT_CPU = 2'b01;
    localparam logic [NO_OF_MASTERS-1:0] GRANT_DMA = 2'b10;

    state_t                     r_state;
    state_t                     w_state_next;
    logic [NO_OF_MASTERS-1:0]   r_grant;
    logic [NO_OF_MASTERS-1:0]   w_grant_next;
    hmaster_t                   r_master;
    logic                       r_mastlock;
    logic [4:0]                 r_beats_left;
    logic [4:0]                 w_beats_next;
    logic                       r_incr;

    htrans_t                    w_trans;
    hburst_t                    w_burst;
    hresp_t                     w_resp;
    logic [4:0]                 w_burst_len;
    logic                       w_nonseq_acc;
    logic                       w_seq_acc;
    logic                       w_err_term;
    logic                       w_idle_term;
    logic                       w_last_beat;
    logic                       w_fixed_start;
    logic                       w_in_incr;
    logic                       w_incr_hold;
    logic                       w_lock_hold;
    logic                       w_rearb_open;
    hmaster_t                   w_grant_idx;

    assign w_trans = htrans_t'(HTRANS);
    assign w_burst = hburst_t'(HBURST);
    assign w_resp  = hresp_t'(HRESP);

    // Beats remaining after the NONSEQ beat of the burst now starting.
    always_comb begin
        w_burst_len = 5'd0;
        case (w_burst)
            HBURST_WRAP4,  HBURST_INCR4:  w_burst_len = 5'd3;
            HBURST_WRAP8,  HBURST_INCR8:  w_burst_len = 5'd7;
            HBURST_WRAP16, HBURST_INCR16: w_burst_len = 5'd15;
            default:                      w_burst_len = 5'd0;
        endcase
    end

    assign w_nonseq_acc  = HREADY && (w_trans == HTRANS_NONSEQ);
    assign w_seq_acc     = HREADY && (w_trans == HTRANS_SEQ);
    // First cycle of a two-cycle ERROR/RETRY/SPLIT response.
    assign w_err_term    = !HREADY && (w_resp != HRESP_OKAY);
    assign w_idle_term   = HREADY && (w_trans == HTRANS_IDLE) && (r_beats_left != 5'd0);
    // Address phase of the final beat of a fixed burst is being accepted.
    assign w_last_beat   = (r_state == ST_BURST) && w_seq_acc && (r_beats_left == 5'd1);
    // A fixed burst is starting: keep the grant closed from its first beat.
    assign w_fixed_start = (w_trans == HTRANS_NONSEQ) && (w_burst_len != 5'd0);

    assign w_grant_idx   = r_grant[1] ? MASTER_DMA : MASTER_CPU;

    // An INCR burst is running while the owner issues its NONSEQ INCR or
    // any following SEQ/BUSY beat.
    assign w_in_incr   = ((w_trans == HTRANS_NONSEQ) && (w_burst == HBURST_INCR)) ||
                         (r_incr && ((w_trans == HTRANS_SEQ) || (w_trans == HTRANS_BUSY)));
    // Only hold while the INCR owner still holds the grant; once the grant
    // has moved the old owner is just finishing its address phase.
    assign w_incr_hold = w_in_incr && HBUSREQ[r_master] && r_grant[r_master];
    // A granted master asking for a locked sequence keeps its grant so the
    // lock cannot be split from the ownership it is attached to.
    assign w_lock_hold = HBUSREQ[w_grant_idx] && HLOCK[w_grant_idx];

    always_comb begin
        w_rearb_open = 1'b0;
        case (r_state)
            ST_PARK, ST_OWN: w_rearb_open = !w_incr_hold && !w_lock_hold && !w_fixed_start;
            ST_BURST:        w_rearb_open = w_last_beat;
            default:         w_rearb_open = 1'b0;
        endcase
    end

    // Grant selection; the decision only takes effect on an HREADY edge.
    always_comb begin
        w_grant_next = r_grant;
        if (w_rearb_open && HREADY) begin
            case (HBUSREQ)
                2'b01:   w_grant_next = GRANT_CPU;
                2'b10:   w_grant_next = GRANT_DMA;
`ifdef AHB_ARB_ROUND_ROBIN_EN
                // Contention: hand over to whoever was not granted last.
                2'b11:   w_grant_next = r_grant[1] ? GRANT_CPU : GRANT_DMA;
`else
                2'b11:   w_grant_next = GRANT_CPU;
`endif
                default: w_grant_next = GRANT_CPU;
            endcase
        end
    end

    // Beat counter: a new NONSEQ always loads, so it wins over any
    // termination seen in the same cycle.
    always_comb begin
        w_beats_next = r_beats_left;
        if (w_nonseq_acc) begin
            w_beats_next = w_burst_len;
        end else if (w_err_term || w_idle_term) begin
            w_beats_next = 5'd0;
        end else if (w_seq_acc && (r_beats_left != 5'd0)) begin
            w_beats_next = r_beats_left - 5'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_nonseq_acc && (w_burst_len != 5'd0)) begin
            w_state_next = ST_BURST;
        end else if (w_err_term || w_idle_term) begin
            w_state_next = ST_OWN;
        end else begin
            case (r_state)
                ST_BURST: begin
                    if (w_last_beat) begin
                        w_state_next = HLOCK[r_master] ? ST_LOCK : ST_OWN;
                    end
                end
                ST_LOCK: begin
                    // Lock released once the owner drops HLOCK and the
                    // transfer in flight completes.
                    if (HREADY && !HLOCK[r_master]) begin
                        w_state_next = ST_OWN;
                    end
                end
                default: begin
                    if (HREADY) begin
                        if (w_lock_hold) begin
                            w_state_next = ST_LOCK;
                        end else if (HBUSREQ == '0) begin
                            w_state_next = ST_PARK;
                        end else begin
                            w_state_next = ST_OWN;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= ST_PARK;
            r_grant      <= GRANT_CPU;
            r_master     <= MASTER_CPU;
            r_mastlock   <= 1'b0;
            r_beats_left <= 5'd0;
            r_incr       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_beats_left <= w_beats_next;
            // Ownership follows the grant on every accepted address phase,
            // so it lags a grant change by at least one cycle.
            if (HREADY) begin
                r_master   <= w_grant_idx;
                r_mastlock <= HLOCK[w_grant_idx];
            end
            if (w_nonseq_acc) begin
                r_incr <= (w_burst == HBURST_INCR);
            end else if (w_err_term) begin
                r_incr <= 1'b0;
            end
        end
    end

    assign HGRANT    = r_grant;
    assign HMASTER   = r_master;
    assign HMASTLOCK = r_mastlock;

endmodule
